// File: rtl/peak_window_ctrl.sv
// peak_window_ctrl: window framing and drain stage behind the 8-bit min/max
// peak detector. It frames DECIM+1 sample windows, clears and enables the
// detector, and writes each captured MAX/MIN pair as two bytes to sample memory.
// Optional build macro: PEAK_ERR_CNT_EN adds ERR_CNT, a saturating count of
// captures where the detector reported MIN_IN > MAX_IN.
module peak_window_ctrl #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned ADDR_W = 18
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              STOP,
  input  logic [DIV_W-1:0]  DECIM,
  input  logic [ADDR_W-1:0] PAIRS,
  input  logic              SAMPLE_VALID,
  input  logic [7:0]        MAX_IN,
  input  logic [7:0]        MIN_IN,
  output logic              PD_EN,
  output logic              PD_CLR_N,
  output logic              WR_REQ,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [7:0]        WR_DATA,
  input  logic              WR_ACK,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVR
`ifdef PEAK_ERR_CNT_EN
  ,
  output logic [7:0]        ERR_CNT
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, CAPT} win_state_t;
  typedef enum logic [1:0] {W_IDLE, W_MAX, W_MIN} wr_state_t;

  localparam logic [DIV_W-1:0]  ONE_D = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};

  win_state_t        win_state, win_next;
  wr_state_t         wr_state, wr_next;

  logic [DIV_W-1:0]  decim_r;
  logic [ADDR_W-1:0] pairs_r;
  logic [DIV_W-1:0]  win_cnt;
  logic [ADDR_W-1:0] cap_cnt;
  logic [ADDR_W-1:0] pair_cnt;
  logic [7:0]        hold_max;
  logic [7:0]        hold_min;
  logic              hold_full;
  logic              abort_r;

  logic              start_ok;
  logic              win_tick;
  logic              win_end;
  logic              cap_fire;
  logic              min_ack;
  logic              cap_accept;
  logic              cap_drop;
  logic              cap_last;
  logic [ADDR_W-1:0] cap_cnt_inc;
  logic [ADDR_W-1:0] pair_cnt_inc;

  // Handshake and window qualifiers shared by both FSMs
  always_comb begin
    cap_cnt_inc  = cap_cnt + ONE_A;
    pair_cnt_inc = pair_cnt + ONE_A;
    BUSY         = (win_state != IDLE) || hold_full || (wr_state != W_IDLE);
    start_ok     = START && !BUSY;
    win_tick     = SAMPLE_VALID && (win_state == RUN) && !STOP;
    win_end      = win_tick && (win_cnt == decim_r);
    cap_fire     = (win_state == CAPT) && !STOP;
    min_ack      = (wr_state == W_MIN) && WR_ACK;
    // The hold slot frees on the MIN ack edge, so a capture landing on that
    // same edge is accepted and chained straight into the next MAX write.
    cap_accept   = cap_fire && (!hold_full || min_ack);
    cap_drop     = cap_fire && hold_full && !min_ack;
    cap_last     = cap_accept && (pairs_r != '0) && (cap_cnt_inc == pairs_r);
  end

  // Window FSM next state and detector control
  always_comb begin
    win_next = win_state;
    PD_EN    = 1'b0;
    PD_CLR_N = 1'b0;
    case (win_state)
      IDLE: begin
        if (start_ok) win_next = RUN;
      end
      RUN: begin
        PD_CLR_N = 1'b1;
        PD_EN    = SAMPLE_VALID;
        if (STOP)         win_next = IDLE;
        else if (win_end) win_next = CAPT;
      end
      CAPT: begin
        if (STOP || cap_last) win_next = IDLE;
        else                  win_next = RUN;
      end
      default: win_next = IDLE;
    endcase
  end

  // Window FSM state, window length and capture counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      win_state <= IDLE;
      decim_r   <= '0;
      pairs_r   <= '0;
      win_cnt   <= '0;
      cap_cnt   <= '0;
    end else begin
      win_state <= win_next;
      if (start_ok) begin
        decim_r <= DECIM;
        pairs_r <= PAIRS;
        cap_cnt <= '0;
      end else if (cap_accept) begin
        cap_cnt <= cap_cnt_inc;
      end
      if (start_ok || STOP) begin
        win_cnt <= '0;
      end else if (win_tick) begin
        win_cnt <= win_end ? '0 : (win_cnt + ONE_D);
      end
    end
  end

  // Single-entry hold register between capture and memory write
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_max  <= '0;
      hold_min  <= '0;
      hold_full <= 1'b0;
    end else if (cap_accept) begin
      hold_max  <= MAX_IN;
      hold_min  <= MIN_IN;
      hold_full <= 1'b1;
    end else if (min_ack) begin
      hold_full <= 1'b0;
    end
  end

  // Write FSM next state
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (hold_full) wr_next = W_MAX;
      W_MAX:   if (WR_ACK)    wr_next = W_MIN;
      W_MIN:   if (WR_ACK)    wr_next = cap_accept ? W_MAX : W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  // Write FSM state and memory port registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_state <= W_IDLE;
      WR_REQ   <= 1'b0;
      WR_ADDR  <= '0;
      WR_DATA  <= '0;
      pair_cnt <= '0;
    end else begin
      wr_state <= wr_next;
      if (start_ok) begin
        WR_ADDR  <= '0;
        pair_cnt <= '0;
      end else begin
        case (wr_state)
          W_IDLE: begin
            if (hold_full) begin
              WR_REQ  <= 1'b1;
              WR_DATA <= hold_max;
            end
          end
          W_MAX: begin
            if (WR_ACK) begin
              WR_ADDR <= WR_ADDR + ONE_A;
              WR_DATA <= hold_min;
            end
          end
          W_MIN: begin
            if (WR_ACK) begin
              WR_ADDR  <= WR_ADDR + ONE_A;
              pair_cnt <= pair_cnt_inc;
              if (cap_accept) WR_DATA <= MAX_IN;
              else            WR_REQ  <= 1'b0;
            end
          end
          default: WR_REQ <= 1'b0;
        endcase
      end
    end
  end

  // Sticky completion, overrun and abort flags
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DONE    <= 1'b0;
      OVR     <= 1'b0;
      abort_r <= 1'b0;
    end else if (start_ok) begin
      DONE    <= 1'b0;
      OVR     <= 1'b0;
      abort_r <= 1'b0;
    end else begin
      if (STOP) abort_r <= 1'b1;
      if (min_ack && (pairs_r != '0) && (pair_cnt_inc == pairs_r) && !abort_r)
        DONE <= 1'b1;
      if (cap_drop || ((win_state == CAPT) && SAMPLE_VALID))
        OVR <= 1'b1;
    end
  end

`ifdef PEAK_ERR_CNT_EN
  // Saturating count of inconsistent detector pairs seen at capture
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ERR_CNT <= '0;
    end else if (start_ok) begin
      ERR_CNT <= '0;
    end else if (cap_fire && (MIN_IN > MAX_IN) && (ERR_CNT != 8'hFF)) begin
      ERR_CNT <= ERR_CNT + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_peak_window_ctrl.sv
// Directed self-checking bench for peak_window_ctrl (ADDR_W=4 so the address
// wrap is reachable). Build with PEAK_ERR_CNT_EN to also cover ERR_CNT.
module tb_peak_window_ctrl;
  localparam int unsigned DIV_W  = 16;
  localparam int unsigned ADDR_W = 4;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              START = 1'b0;
  logic              STOP = 1'b0;
  logic [DIV_W-1:0]  DECIM = '0;
  logic [ADDR_W-1:0] PAIRS = '0;
  logic              SAMPLE_VALID = 1'b0;
  logic [7:0]        MAX_IN = '0;
  logic [7:0]        MIN_IN = '0;
  logic              WR_ACK = 1'b0;
  logic              PD_EN, PD_CLR_N, WR_REQ, BUSY, DONE, OVR;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [7:0]        WR_DATA;
`ifdef PEAK_ERR_CNT_EN
  logic [7:0]        ERR_CNT;
`endif

  int checks = 0;
  int failures = 0;
  bit ack_en = 1'b0;

  logic [ADDR_W-1:0] wa[$];
  logic [7:0]        wd[$];
  logic [ADDR_W-1:0] ea[$];
  logic [7:0]        ed[$];

  peak_window_ctrl #(.DIV_W(DIV_W), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .DECIM(DECIM),
    .PAIRS(PAIRS), .SAMPLE_VALID(SAMPLE_VALID), .MAX_IN(MAX_IN),
    .MIN_IN(MIN_IN), .PD_EN(PD_EN), .PD_CLR_N(PD_CLR_N), .WR_REQ(WR_REQ),
    .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_ACK(WR_ACK), .BUSY(BUSY),
    .DONE(DONE), .OVR(OVR)
`ifdef PEAK_ERR_CNT_EN
    , .ERR_CNT(ERR_CNT)
`endif
  );

  initial forever #5 CLK = ~CLK;

  // Memory model: one-cycle ack per byte, logging every accepted write
  initial forever begin
    @(negedge CLK);
    if (WR_ACK) begin
      WR_ACK = 1'b0;
    end else if (ack_en && WR_REQ && !RST) begin
      WR_ACK = 1'b1;
      wa.push_back(WR_ADDR);
      wd.push_back(WR_DATA);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_acq(input logic [DIV_W-1:0] d, input logic [ADDR_W-1:0] p);
    DECIM = d;
    PAIRS = p;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic stop_acq();
    STOP = 1'b1;
    @(negedge CLK);
    STOP = 1'b0;
  endtask

  // nsamp strobes spaced 2 CLK; returns gap+1 cycles after the CAPT cycle
  task automatic window(input logic [7:0] mx, input logic [7:0] mn,
                        input int nsamp, input int gap);
    MAX_IN = mx;
    MIN_IN = mn;
    for (int i = 0; i < nsamp; i++) begin
      SAMPLE_VALID = 1'b1;
      #1 chk("pd_en_strobe", PD_EN, 1);
      @(negedge CLK);
      SAMPLE_VALID = 1'b0;
      if (i != nsamp - 1) @(negedge CLK);
    end
    #1;
    chk("capt_clr_n", PD_CLR_N, 0);
    chk("capt_pd_en", PD_EN, 0);
    repeat (gap + 1) @(negedge CLK);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (BUSY && n < max_cyc) begin
      @(negedge CLK);
      n++;
    end
    chk("idle_timeout_busy", BUSY, 0);
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    ea.push_back(a);
    ed.push_back(d);
  endtask

  task automatic compare_log(input string tag);
    chk({tag, "_len"}, wa.size(), ea.size());
    for (int i = 0; i < ea.size(); i++) begin
      if (i < wa.size()) begin
        chk({tag, "_addr"}, wa[i], ea[i]);
        chk({tag, "_data"}, wd[i], ed[i]);
      end
    end
    wa.delete(); wd.delete(); ea.delete(); ed.delete();
  endtask

  initial begin
    logic [7:0] mx, mn;

    // Reset values
    @(negedge CLK);
    chk("rst_pd_en", PD_EN, 0);
    chk("rst_clr_n", PD_CLR_N, 0);
    chk("rst_req", WR_REQ, 0);
    chk("rst_addr", WR_ADDR, 0);
    chk("rst_data", WR_DATA, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_ovr", OVR, 0);
    RST = 1'b0;
    @(negedge CLK);

    // Basic window: DECIM=3, PAIRS=2
    ack_en = 1'b1;
    start_acq(3, 2);
    chk("basic_busy", BUSY, 1);
    chk("basic_run_clr_n", PD_CLR_N, 1);
    window(8'hC8, 8'h10, 4, 0);
    window(8'h80, 8'h40, 4, 0);
    wait_idle(100);
    expect_wr(0, 8'hC8); expect_wr(1, 8'h10);
    expect_wr(2, 8'h80); expect_wr(3, 8'h40);
    compare_log("basic");
    chk("basic_done", DONE, 1);
    chk("basic_busy_end", BUSY, 0);
    chk("basic_idle_clr_n", PD_CLR_N, 0);
    chk("basic_req_end", WR_REQ, 0);
    chk("basic_ovr", OVR, 0);

    // Backpressure overrun: no ack while several windows close
    ack_en = 1'b0;
    start_acq(0, 0);
    chk("bp_done_cleared", DONE, 0);
    window(8'h11, 8'h22, 1, 0);
    for (int i = 0; i < 4; i++) window(8'h33, 8'h44, 1, 0);
    chk("bp_req_held", WR_REQ, 1);
    chk("bp_data_held", WR_DATA, 8'h11);
    chk("bp_addr_held", WR_ADDR, 0);
    chk("bp_ovr", OVR, 1);
    stop_acq();
    ack_en = 1'b1;
    wait_idle(100);
    expect_wr(0, 8'h11); expect_wr(1, 8'h22);
    compare_log("bp");
    chk("bp_done", DONE, 0);

    // Address wrap in continuous mode: 9 windows on a 16-byte space
    start_acq(0, 0);
    chk("wrap_ovr_cleared", OVR, 0);
    for (int i = 0; i < 9; i++) begin
      mx = 8'hA0 + 8'(i);
      mn = 8'h50 + 8'(i);
      window(mx, mn, 1, 6);
      expect_wr(ADDR_W'(2 * i), mx);
      expect_wr(ADDR_W'(2 * i + 1), mn);
    end
    compare_log("wrap");
    chk("wrap_done_running", DONE, 0);
    chk("wrap_busy_running", BUSY, 1);
    chk("wrap_addr_after", WR_ADDR, 2);
    stop_acq();
    wait_idle(100);
    chk("wrap_done_stopped", DONE, 0);

    // Strobe violation: SAMPLE_VALID during CAPT is lost, DECIM=1
    start_acq(1, 0);
    MAX_IN = 8'h70; MIN_IN = 8'h07;
    SAMPLE_VALID = 1'b1; @(negedge CLK);
    SAMPLE_VALID = 1'b0; @(negedge CLK);
    SAMPLE_VALID = 1'b1; @(negedge CLK);
    SAMPLE_VALID = 1'b1;
    #1 chk("viol_pd_en_capt", PD_EN, 0);
    chk("viol_clr_n_capt", PD_CLR_N, 0);
    @(negedge CLK);
    SAMPLE_VALID = 1'b0;
    #1 chk("viol_ovr", OVR, 1);
    @(negedge CLK);
    SAMPLE_VALID = 1'b1; @(negedge CLK);
    SAMPLE_VALID = 1'b0;
    #1 chk("viol_no_early_capt", PD_CLR_N, 1);
    @(negedge CLK);
    SAMPLE_VALID = 1'b1; @(negedge CLK);
    SAMPLE_VALID = 1'b0;
    #1 chk("viol_second_capt", PD_CLR_N, 0);
    @(negedge CLK);
    stop_acq();
    wait_idle(100);
    expect_wr(0, 8'h70); expect_wr(1, 8'h07);
    expect_wr(2, 8'h70); expect_wr(3, 8'h07);
    compare_log("viol");

    // STOP during W_MAX; START while busy is ignored
    ack_en = 1'b0;
    start_acq(0, 3);
    window(8'h5A, 8'hA5, 1, 2);
    chk("stop_req_wmax", WR_REQ, 1);
    chk("stop_data_wmax", WR_DATA, 8'h5A);
    stop_acq();
    chk("stop_clr_n", PD_CLR_N, 0);
    chk("stop_busy_pending", BUSY, 1);
    start_acq(5, 1);
    chk("start_ignored_clr_n", PD_CLR_N, 0);
    ack_en = 1'b1;
    wait_idle(100);
    expect_wr(0, 8'h5A); expect_wr(1, 8'hA5);
    compare_log("stop");
    chk("stop_done", DONE, 0);
    chk("stop_req_end", WR_REQ, 0);

`ifdef PEAK_ERR_CNT_EN
    // ERR_CNT saturation and clear on START
    start_acq(0, 0);
    for (int i = 0; i < 300; i++) begin
      window(8'h20, 8'h90, 1, 6);
      if (i == 9) chk("err_cnt_10", ERR_CNT, 10);
    end
    chk("err_cnt_sat", ERR_CNT, 255);
    chk("err_pair_written", wa.size(), 600);
    wa.delete(); wd.delete();
    stop_acq();
    wait_idle(100);
    start_acq(0, 0);
    chk("err_cnt_cleared", ERR_CNT, 0);
    stop_acq();
    wait_idle(100);
    wa.delete(); wd.delete();
`endif

    // Asynchronous reset in the middle of a write
    ack_en = 1'b0;
    start_acq(0, 0);
    window(8'hEE, 8'h01, 1, 2);
    chk("rstw_req_before", WR_REQ, 1);
    #2 RST = 1'b1;
    #1;
    chk("rstw_req", WR_REQ, 0);
    chk("rstw_busy", BUSY, 0);
    chk("rstw_data", WR_DATA, 0);
    chk("rstw_clr_n", PD_CLR_N, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
